// File: rtl/dmem_dump_unit.sv
// Data-memory dump engine: on the end-of-program trap it halts the core and streams DMEM bytes out.
// Optional feature: define DMEM_DUMP_CHECKSUM_EN to append an 8-bit mod-256 sum as a final byte.
module dmem_dump_unit #(
  parameter int          DMEM_SIZE = 1024,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] TRAP_WORD = 32'h44000300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  output logic              halt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
`ifdef DMEM_DUMP_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DMEM_SIZE - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]        r_dout, w_dout_nxt;
  logic              r_halt, r_rd, r_valid, r_done;
  logic              w_handshake;
`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [7:0]        r_csum, w_csum_nxt;
`endif

  assign w_handshake = r_valid & dout_ready;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_dout_nxt  = r_dout;
`ifdef DMEM_DUMP_CHECKSUM_EN
    w_csum_nxt  = r_csum;
`endif
    case (r_state)
      ST_IDLE: begin
`ifdef DMEM_DUMP_CHECKSUM_EN
        w_csum_nxt = '0;
`endif
        if (instr == TRAP_WORD) begin
          w_state_nxt = ST_READ;
          w_addr_nxt  = '0;
        end
      end
      ST_READ: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        w_dout_nxt  = mem_rdata;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (w_handshake) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
          w_csum_nxt = r_csum + r_dout;
`endif
          if (r_addr == LAST_ADDR) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
            // The sum must include the byte being accepted on this very edge.
            w_dout_nxt  = r_csum + r_dout;
            w_state_nxt = ST_CSUM;
`else
            w_state_nxt = ST_DONE;
`endif
          end else begin
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_state_nxt = ST_READ;
          end
        end
      end
`ifdef DMEM_DUMP_CHECKSUM_EN
      ST_CSUM: if (w_handshake) w_state_nxt = ST_DONE;
`endif
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered straight from the next state, so they line up with the state they describe.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_dout  <= '0;
      r_halt  <= 1'b0;
      r_rd    <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_dout  <= w_dout_nxt;
      r_halt  <= (w_state_nxt != ST_IDLE);
      r_rd    <= (w_state_nxt == ST_READ);
`ifdef DMEM_DUMP_CHECKSUM_EN
      r_valid <= (w_state_nxt == ST_SEND) || (w_state_nxt == ST_CSUM);
`else
      r_valid <= (w_state_nxt == ST_SEND);
`endif
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

`ifdef DMEM_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_csum <= '0;
    else     r_csum <= w_csum_nxt;
  end
`endif

  assign halt       = r_halt;
  assign mem_addr   = r_addr;
  assign mem_rd     = r_rd;
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_dmem_dump_unit.sv
// Scoreboard bench for dmem_dump_unit with a 4-byte synchronous-read memory model.
module tb_dmem_dump_unit;
  localparam int          N       = 4;
  localparam int          AW      = 3;
  localparam logic [31:0] TRAP    = 32'h44000300;
  localparam logic [31:0] NOP     = 32'h44000200;
  localparam int          TIMEOUT = 200;
`ifdef DMEM_DUMP_CHECKSUM_EN
  localparam int          DONE_K  = 3 * N + 1;
`else
  localparam int          DONE_K  = 3 * N;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          halt, mem_rd, dout_valid, dout_ready, done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata, dout;
  logic [7:0]    mem [2**AW];
  logic [7:0]    sb [$];
  int            n_tests = 0;
  int            n_fail  = 0;

  dmem_dump_unit #(.DMEM_SIZE(N), .ADDR_W(AW), .TRAP_WORD(TRAP)) dut (
    .clk(clk), .rst(rst), .instr(instr), .halt(halt), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_halt"},  halt, 0);
    check({tag, "_addr"},  mem_addr, 0);
    check({tag, "_rd"},    mem_rd, 0);
    check({tag, "_dout"},  dout, 0);
    check({tag, "_valid"}, dout_valid, 0);
    check({tag, "_done"},  done, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst   = 1'b1;
    instr = TRAP;
    #1 check_idle_outputs("rst_async");
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("rst_held");
    @(negedge clk);
    rst   = 1'b0;
    instr = NOP;
    sb.delete();
    @(posedge clk);
    #1 check("post_rst_idle", halt, 0);
  endtask

  // Cycle (counted from the trap edge) at which byte i is first presented.
  function automatic int exp_k(input int i, input int stall_idx, input int stall_len);
    int k;
    k = (i < N) ? 2 + 3 * i : 3 * N;
    if (i > stall_idx) k += stall_len;
    return k;
  endfunction

  task automatic run_dump(input int stall_idx, input int stall_len, input int abort_idx);
    int         k, idx, held;
    bit         first;
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < N; i++) begin
      sb.push_back(mem[i]);
      sum += mem[i];
    end
`ifdef DMEM_DUMP_CHECKSUM_EN
    sb.push_back(sum);
`endif
    dout_ready = 1'b1;
    instr      = TRAP;
    @(posedge clk);
    #1 instr = NOP;
    check("trap_halt", halt, 1);
    check("trap_addr", mem_addr, 0);
    check("trap_rd", mem_rd, 1);
    check("trap_valid", dout_valid, 0);
    k = 0; idx = 0; held = 0; first = 1'b1;
    while (!done && k < TIMEOUT && idx != abort_idx) begin
      check("halt_held", halt, 1);
      check("addr_bound", mem_addr <= AW'(N - 1), 1);
      if (dout_valid) begin
        check("rd_in_send", mem_rd, 0);
        if (sb.size() == 0) begin
          check("extra_byte", dout, 0);
          break;
        end
        if (first) begin
          check("byte_time", k, exp_k(idx, stall_idx, stall_len));
          first = 1'b0;
        end
        check("byte_val", dout, sb[0]);
        dout_ready = !(idx == stall_idx && held < stall_len);
        if (idx == stall_idx) held++;
        if (dout_ready) begin
          void'(sb.pop_front());
          if (idx == stall_idx) check("stall_hold", held, stall_len + 1);
          idx++;
          first = 1'b1;
        end
      end else begin
        dout_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1 k++;
    end
    dout_ready = 1'b1;
    if (abort_idx < 0) begin
      check("no_timeout", k < TIMEOUT, 1);
      check("done_time", k, DONE_K + stall_len);
      check("sb_empty", sb.size(), 0);
      instr = TRAP;
      repeat (5) begin
        @(posedge clk);
        #1;
        check("done_held", done, 1);
        check("halt_done", halt, 1);
        check("no_restart_rd", mem_rd, 0);
        check("valid_done", dout_valid, 0);
      end
      instr = NOP;
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = (i < N) ? 8'(8'h11 * (i + 1)) : 8'h00;
    rst        = 1'b1;
    instr      = TRAP;
    dout_ready = 1'b0;
    apply_reset();

    instr = NOP;
    repeat (20) begin
      @(posedge clk);
      #1;
      check("nontrap_halt", halt, 0);
      check("nontrap_rd", mem_rd, 0);
      check("nontrap_valid", dout_valid, 0);
    end

    run_dump(-1, 0, -1);
    apply_reset();
    run_dump(1, 5, -1);
    apply_reset();
    run_dump(-1, 0, 2);
    check("abort_in_progress", halt, 1);
    apply_reset();
    run_dump(-1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dmem_dump_unit.md
# dmem_dump_unit

Hardware data-memory dump engine for the single-cycle core. It watches the fetched instruction for the end-of-program trap (`0x44000300`). On that trap it halts the core, reads every byte of data memory from address 0 upward, and streams the bytes out on a valid/ready byte interface. This makes the post-run memory image observable on silicon or FPGA, not only in simulation. It sits in `toplevel` beside the IFU and data memory and owns the data-memory read port while halted.

## Interface

Parameters:
- `DMEM_SIZE`, default 1024: number of bytes dumped. Must satisfy 1 ≤ `DMEM_SIZE` ≤ 2^`ADDR_W`.
- `ADDR_W`, default 10: byte-address width.
- `TRAP_WORD`, default 32'h44000300: instruction encoding that triggers the dump.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: current instruction from the IFU.
- `halt` out 1: freezes the PC and gates register-file and data-memory writes.
- `mem_addr` out `ADDR_W`: data-memory byte address.
- `mem_rd` out 1: read strobe.
- `mem_rdata` in 8: read data, valid exactly one cycle after `mem_rd`.
- `dout` out 8: streamed byte.
- `dout_valid` out 1: `dout` holds a byte.
- `dout_ready` in 1: sink accepts the byte.
- `done` out 1: dump complete.

## Operation

- All outputs are registered. Reset values: `halt`=0, `mem_addr`=0, `mem_rd`=0, `dout`=0, `dout_valid`=0, `done`=0. Reset puts the FSM in IDLE.
- FSM states are IDLE, READ, WAIT, SEND and DONE.
- **IDLE**
  - If `instr` == `TRAP_WORD` at a rising edge, go to READ, set `halt`=1 and set `mem_addr`=0.
  - Any other `instr` keeps the FSM in IDLE.
- **READ**: `mem_rd`=1 for exactly one cycle, then go to WAIT.
- **WAIT**: `mem_rd`=0. Load `mem_rdata` into `dout`, set `dout_valid`=1, go to SEND.
- **SEND**
  - Hold `dout` and `dout_valid` stable while `dout_ready`=0.
  - A handshake is `dout_valid` & `dout_ready` at a rising edge. On handshake:
    - if `mem_addr` == `DMEM_SIZE`-1, clear `dout_valid` and go to DONE;
    - otherwise increment `mem_addr`, clear `dout_valid` and go to READ.
- **DONE**: `done`=1 and `halt`=1 are held until `rst`. `mem_rd`=0 and `dout_valid`=0.
- Trap matches outside IDLE are ignored. A dump is never restarted except through reset.
- `mem_addr` never exceeds `DMEM_SIZE`-1; there is no wrap-around.
- `dout_ready` is ignored whenever `dout_valid`=0.
- Asserting `rst` mid-dump aborts immediately, whatever the state. All outputs return to their reset values and the next trap restarts from address 0.

## Timing

- Trap sampled at edge N: `halt` and state READ are visible after edge N. `mem_rd` is high during cycle N+1.
- First `dout_valid` rises after edge N+2.
- With `dout_ready` held at 1, bytes are spaced 3 cycles apart (READ, WAIT, SEND). `dout_valid` is high for one cycle per byte.
- Total dump time with no backpressure is 3×`DMEM_SIZE` cycles from the trap edge to `done`.
- `done` rises on the edge that completes the final handshake.
- Backpressure adds one cycle per stalled cycle. No `mem_rd` is issued while stalled in SEND.

## Configuration

- Macro: `DMEM_DUMP_CHECKSUM_EN`.
- **Defined**
  - An 8-bit running sum (mod 256) of every dumped byte is kept. It is cleared in IDLE and on reset.
  - After the handshake of byte `DMEM_SIZE`-1, the FSM enters a CSUM state instead of DONE.
  - CSUM presents the sum on `dout` with `dout_valid`=1 and holds it until a handshake, then goes to DONE.
  - The stream is `DMEM_SIZE`+1 bytes long.
- **Undefined**: no sum register and no CSUM state. The stream is exactly `DMEM_SIZE` bytes.

## Test plan

- **Reset:** assert `rst` with `instr`=`TRAP_WORD` → all outputs are 0 while `rst` is high and the FSM stays in IDLE.
- **Basic dump:** `DMEM_SIZE`=4, memory = 11 22 33 44, `dout_ready`=1, trap at edge N → `halt` rises after edge N. `dout` shows 11, 22, 33, 44 with `dout_valid` pulses 3 cycles apart, the first after edge N+2. `done`=1 after edge N+12 and stays high.
- **Backpressure:** same setup, `dout_ready`=0 for 5 cycles while byte 22 is presented → `dout` holds 22 with `dout_valid`=1 for 6 cycles. No `mem_rd` occurs during the stall. Byte order is unchanged.
- **Non-trap:** `instr`=32'h44000200 for 20 cycles → `halt`, `mem_rd` and `dout_valid` stay 0.
- **Mid-dump reset:** assert `rst` after byte 22 is accepted → all outputs clear. A new trap restarts at `mem_addr`=0 and the first byte is 11.
- **Checksum (`DMEM_DUMP_CHECKSUM_EN`):** basic-dump stimulus → fifth byte is 8'hAA, then `done`=1.
